// File: rtl/tt_pad_cfg.sv
// Double-buffered pad configuration: shadow writes, guarded commit with OE blanking.
// Optional registered readback of the active config when TT_PAD_CFG_READBACK_EN is defined.
module tt_pad_cfg #(
  parameter int N_BI  = 16,
  parameter int GUARD = 2,
  localparam int AW   = (N_BI > 1) ? $clog2(N_BI) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [5:0]      cfg_data,
  input  logic            cfg_commit,
  output logic            cfg_busy,
  output logic            cfg_err,
  input  logic [N_BI-1:0] core_out,
  input  logic [N_BI-1:0] core_oe,
  output logic [N_BI-1:0] core_in,
  input  logic [N_BI-1:0] pad_Y,
  output logic [N_BI-1:0] pad_A,
  output logic [N_BI-1:0] pad_OE,
  output logic [N_BI-1:0] pad_IE,
  output logic [N_BI-1:0] pad_SL,
  output logic [N_BI-1:0] pad_CS,
  output logic [N_BI-1:0] pad_PD,
  output logic [N_BI-1:0] pad_PU
`ifdef TT_PAD_CFG_READBACK_EN
  ,
  input  logic [AW-1:0]   rb_addr,
  output logic [5:0]      rb_data
`endif
);

  typedef enum logic [1:0] {IDLE, BLANK, APPLY} state_t;

  // Entry layout {PU,PD,CS,SL,IE,OE}; reset leaves inputs enabled only.
  localparam logic [5:0] CFG_RST = 6'b000010;
  localparam logic [AW:0] N_LIM  = (AW + 1)'(N_BI);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [5:0]  shadow_q [N_BI];
  logic [5:0]  shadow_d [N_BI];
  logic [5:0]  active_q [N_BI];
  logic [5:0]  active_d [N_BI];
  logic        idle;
  logic        addr_ok;

  assign idle    = (state_q == IDLE);
  assign addr_ok = ({1'b0, cfg_addr} < N_LIM);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (addr_ok) shadow_d[cfg_addr] = cfg_data;
          else         err_d = 1'b1;
        end
        if (cfg_commit) begin
          state_d = BLANK;
          cnt_d   = 4'(GUARD);
        end
      end
      BLANK: begin
        if (cnt_q <= 4'd1) state_d = APPLY;
        else               cnt_d   = cnt_q - 4'd1;
      end
      APPLY: begin
        active_d = shadow_q;
        state_d  = IDLE;
        cnt_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < N_BI; i++) begin
        shadow_q[i] <= CFG_RST;
        active_q[i] <= CFG_RST;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign cfg_ready = idle;
  assign cfg_busy  = ~idle;
  assign cfg_err   = err_q;
  assign pad_A     = core_out;

  always_comb begin
    pad_OE  = '0;
    pad_IE  = '0;
    pad_SL  = '0;
    pad_CS  = '0;
    pad_PD  = '0;
    pad_PU  = '0;
    core_in = '0;
    for (int unsigned i = 0; i < N_BI; i++) begin
      pad_OE[i]  = active_q[i][0] & core_oe[i] & idle;
      pad_IE[i]  = active_q[i][1];
      pad_SL[i]  = active_q[i][2];
      pad_CS[i]  = active_q[i][3];
      pad_PD[i]  = active_q[i][4];
      pad_PU[i]  = active_q[i][5];
      core_in[i] = pad_Y[i] & active_q[i][1];
    end
  end

`ifdef TT_PAD_CFG_READBACK_EN
  logic [5:0] rb_data_q, rb_data_d;

  always_comb begin
    rb_data_d = '0;
    if ({1'b0, rb_addr} < N_LIM) rb_data_d = active_q[rb_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rb_data_q <= '0;
    else     rb_data_q <= rb_data_d;
  end

  assign rb_data = rb_data_q;
`endif

endmodule

// File: tb/tb_tt_pad_cfg.sv
// Scoreboard bench for tt_pad_cfg: a cycle-timed model predicts every output each cycle,
// a monitor on the falling edge compares. Readback checked when TT_PAD_CFG_READBACK_EN is defined.
module tb_tt_pad_cfg;
  localparam int N  = 12;
  localparam int G  = 3;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_commit, cfg_busy, cfg_err;
  logic [AW-1:0] cfg_addr;
  logic [5:0]    cfg_data;
  logic [N-1:0]  core_out, core_oe, core_in, pad_Y;
  logic [N-1:0]  pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU;
  logic [AW-1:0] rb_addr;
  logic [5:0]    rb_data;

  always #5 clk = ~clk;

  tt_pad_cfg #(.N_BI(N), .GUARD(G)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .core_out(core_out), .core_oe(core_oe), .core_in(core_in),
    .pad_Y(pad_Y), .pad_A(pad_A), .pad_OE(pad_OE), .pad_IE(pad_IE), .pad_SL(pad_SL),
    .pad_CS(pad_CS), .pad_PD(pad_PD), .pad_PU(pad_PU)
`ifdef TT_PAD_CFG_READBACK_EN
    , .rb_addr(rb_addr), .rb_data(rb_data)
`endif
  );

`ifndef TT_PAD_CFG_READBACK_EN
  assign rb_data = '0;
`endif

  typedef struct packed {
    logic [N-1:0] oe, a, ie, sl, cs, pd, pu, cin;
    logic         rdy, bsy, err;
    logic [5:0]   rb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Reference state: config tables plus the cycle number of an in-flight commit.
  logic [5:0] sh [N];
  logic [5:0] ac [N];
  logic       err_m;
  logic [5:0] rb_m;
  int         commit_cyc;
  int         cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  function automatic bit busy_now();
    return (commit_cyc >= 0) && (cyc > commit_cyc) && (cyc <= commit_cyc + G + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh[i] = 6'b000010;
      ac[i] = 6'b000010;
    end
    err_m      = 1'b0;
    rb_m       = '0;
    commit_cyc = -1;
  endtask

  // Predict this cycle's outputs, advance the model across the next edge, then step.
  task automatic cycle();
    exp_t e;
    bit   busy;
    busy = busy_now();
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.oe[i]  = ac[i][0] & core_oe[i] & ~busy;
      e.ie[i]  = ac[i][1];
      e.sl[i]  = ac[i][2];
      e.cs[i]  = ac[i][3];
      e.pd[i]  = ac[i][4];
      e.pu[i]  = ac[i][5];
      e.cin[i] = pad_Y[i] & ac[i][1];
    end
    e.a   = core_out;
    e.rdy = ~busy;
    e.bsy = busy;
    e.err = err_m;
    e.rb  = rb_m;
    q.push_back(e);

    if (rst) begin
      model_reset();
    end else begin
      rb_m = (int'(rb_addr) < N) ? ac[rb_addr] : 6'd0;
      if (!busy) begin
        if (cfg_valid) begin
          if (int'(cfg_addr) < N) sh[cfg_addr] = cfg_data;
          else                    err_m = 1'b1;
        end
        if (cfg_commit) commit_cyc = cyc;
      end else if (cyc == commit_cyc + G + 1) begin
        for (int i = 0; i < N; i++) ac[i] = sh[i];
        commit_cyc = -1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    cfg_valid  = 0;
    cfg_commit = 0;
    repeat (n) cycle();
  endtask

  task automatic wr(input int addr, input logic [5:0] data, input bit commit);
    cfg_valid  = 1;
    cfg_addr   = AW'(addr);
    cfg_data   = data;
    cfg_commit = commit;
    cycle();
    cfg_valid  = 0;
    cfg_commit = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pad_OE", 64'(pad_OE), 64'(e.oe));
      chk("pad_A", 64'(pad_A), 64'(e.a));
      chk("pad_IE", 64'(pad_IE), 64'(e.ie));
      chk("pad_SL", 64'(pad_SL), 64'(e.sl));
      chk("pad_CS", 64'(pad_CS), 64'(e.cs));
      chk("pad_PD", 64'(pad_PD), 64'(e.pd));
      chk("pad_PU", 64'(pad_PU), 64'(e.pu));
      chk("core_in", 64'(core_in), 64'(e.cin));
      chk("cfg_ready", 64'(cfg_ready), 64'(e.rdy));
      chk("cfg_busy", 64'(cfg_busy), 64'(e.bsy));
      chk("cfg_err", 64'(cfg_err), 64'(e.err));
`ifdef TT_PAD_CFG_READBACK_EN
      chk("rb_data", 64'(rb_data), 64'(e.rb));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    rst = 1; cfg_valid = 0; cfg_commit = 0; cfg_addr = '0; cfg_data = '0;
    core_out = '0; core_oe = '0; pad_Y = '0; rb_addr = '0;
    model_reset();
    @(posedge clk);
    #1;
    core_oe = '1; core_out = 12'h5a3; pad_Y = 12'hfff;
    repeat (3) cycle();
    rst = 0;

    // OE enable on pad 3 held off until the commit has run its course
    wr(3, 6'b000001, 0);
    idle_n(3);
    cfg_commit = 1;
    cycle();
    rb_addr = 3;
    idle_n(G + 3);
    rb_addr = AW'(N);
    idle_n(2);

    // Pad 5 OE with all core_oe high: whole bus blanked during the commit
    wr(5, 6'b000001, 0);
    cfg_commit = 1;
    cycle();
    idle_n(G + 3);

    // Out-of-range address sets a sticky error; later good write keeps it
    wr(13, 6'h3f, 0);
    idle_n(1);
    wr(2, 6'b000100, 1);
    idle_n(G + 3);

    // Write and commit in the same cycle; commit during busy is ignored
    wr(0, 6'b100010, 1);
    wr(1, 6'b111111, 1);
    idle_n(G + 3);

    // Reset in the second blanking cycle drops the pending commit
    wr(7, 6'h3d, 0);
    cfg_commit = 1;
    cycle();
    cfg_commit = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    cfg_commit = 1;
    cycle();
    idle_n(G + 3);

    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      cfg_valid  = $urandom_range(0, 1);
      cfg_addr   = AW'($urandom_range(0, 15));
      cfg_data   = 6'($urandom);
      cfg_commit = ($urandom_range(0, 9) == 0);
      core_out   = N'($urandom);
      core_oe    = N'($urandom);
      pad_Y      = N'($urandom);
      rb_addr    = AW'($urandom_range(0, 15));
      cycle();
    end
    rst = 0;
    idle_n(2);

    done = 1;
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
